rcu_rename_map_table: RTL and testbench
=======================================

Name: rcu_rename_map_table

Overview:
- Two-wide register rename map table in the RCU.
- Sits directly downstream of the physical-register freelist.
  - Pops one or two free physical registers per cycle and maps them to destination architectural registers.
  - Drives the freelist's read, exception-read and write enables.
- Keeps a speculative RAT and an architectural (commit) RAT.
  - On commit, the displaced physical register is returned to the freelist.
  - On exception, the speculative RAT is restored from the architectural RAT.

Parameters:
- ARCH_REG_NUM, 32: number of architectural integer registers; x0 is never renamed.
- ARCH_REG_WIDTH, 5: architectural index width.
- PHY_REG_WIDTH, 6: physical register index width; matches freelist data width.
- FL_NUM_WIDTH, 6: width of the freelist occupancy input.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- excep_rst_i  in  1  flush speculative state
- rn_first_valid_i / rn_second_valid_i  in  1  rename slot valid
- rn_first_rs1_i, rn_first_rs2_i, rn_first_rd_i (and second)  in  ARCH_REG_WIDTH  source/dest architectural registers
- rn_first_rd_wen_i / rn_second_rd_wen_i  in  1  slot writes rd
- rn_ready_o  out  1  bundle accepted this cycle
- rn_first_prs1_o, rn_first_prs2_o, rn_first_prd_o, rn_first_lprd_o (and second)  out  PHY_REG_WIDTH  mapped sources, new dest, previous dest mapping
- fl_num_i  in  FL_NUM_WIDTH  freelist occupancy
- fl_prd_first_i / fl_prd_second_i  in  PHY_REG_WIDTH  freelist rdata_first/rdata_second
- fl_rd_first_en_o / fl_rd_second_en_o  out  1  freelist pop enables
- cm_first_valid_i / cm_second_valid_i  in  1  commit slot valid
- cm_first_rd_i / cm_second_rd_i  in  ARCH_REG_WIDTH  committed dest
- cm_first_prd_i / cm_second_prd_i  in  PHY_REG_WIDTH  committed new mapping
- fl_rd_excep_first_en_o / fl_rd_excep_second_en_o  out  1  freelist commit-pointer advance
- fl_wr_first_en_o / fl_wr_second_en_o  out  1  freelist write enables (registered)
- fl_wdata_first_o / fl_wdata_second_o  out  PHY_REG_WIDTH  freed physical registers (registered)
- perf_rn_stall_cnt_o, perf_rn_insn_cnt_o  out  32  performance counters

Behaviour:
- Reset: both RATs map x_i -> p_i for i = 0..31. Registered outputs fl_wr_*_en_o = 0 and fl_wdata_*_o = 0. Perf counters = 0.
- Slot need: need_k = rn_k_valid & rd_wen_k & (rd_k != 0). need_cnt = need_first + need_second.
- Ready: rn_ready_o = ~excep_rst_i & (fl_num_i >= need_cnt). The bundle is accepted all-or-nothing.
- Pop enables: fl_rd_first_en_o = need_first & rn_ready_o; fl_rd_second_en_o = need_second & rn_ready_o.
  - When only second needs a register, its prd comes from fl_prd_second_i.
  - prd_k = fl_prd_k_i when need_k, else 0.
- Source lookup is combinational from the speculative RAT. Intra-bundle bypass applies when second rs1/rs2 == first rd and need_first: the source takes rn_first_prd_o.
- lprd: first = specRAT[rd_first]. second = rn_first_prd_o if need_first and rd equal, else specRAT[rd_second].
- Speculative RAT update on accept, at the clock edge.
  - Write rd_first then rd_second; second wins on the same rd.
  - x0 is never written.
- Commit, for slots with valid and rd != 0:
  - fl_rd_excep_k_en_o = 1, combinational.
  - archRAT[rd] <= prd, applied in slot order.
  - The freed register is the pre-commit archRAT[rd_first] for first.
  - For second it is cm_first_prd_i if both slots commit the same rd, else archRAT[rd_second].
  - The freed register is presented on fl_wr/fl_wdata one cycle after commit, with first before second.
- Exception (excep_rst_i = 1):
  - Same-cycle commits are applied to archRAT first.
  - specRAT <= post-commit archRAT.
  - Rename is blocked, so there are no pops and no specRAT writes.
  - Frees from same-cycle commits still issue next cycle.
- rst takes priority over excep_rst_i and all updates. Asserting rst mid-operation drops pending frees.

Optional Feature:
- Macro: RCU_RENAME_PERF_EN.
- Defined:
  - perf_rn_stall_cnt_o increments each cycle with any rn valid and ~rn_ready_o.
  - perf_rn_insn_cnt_o adds the count of accepted valid slots.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both outputs are tied to 0 and no counter flops exist.

Test Plan:
- After reset, first renames x1 with fl_prd_first_i = 32 and fl_num_i = 31 -> rn_ready_o = 1, prd = 32, lprd = 1. A later read of x1 gives prs1 = 32.
- Bundle first rd = x5 (prd 33), second rs1 = x5, rd = x5 (prd 34) -> second prs1 = 33, second lprd = 33, specRAT[x5] = 34.
- fl_num_i = 1 with both slots needing a register -> rn_ready_o = 0 and no pop enables. With fl_num_i = 2 -> both pop enables are 1.
- Commit x5 -> 33 then x5 -> 34 in one cycle, with archRAT[x5] = 5 -> next cycle fl_wr_first = 5 and fl_wr_second = 33. Both fl_rd_excep enables = 1.
- Rename x7 -> 40 speculatively, then assert excep_rst_i -> specRAT[x7] = 7 and a subsequent prs1(x7) = 7. rn_ready_o is 0 in the flush cycle.
- Writes to x0 and rd_wen = 0 -> no pop, prd = 0, no RAT change. With RCU_RENAME_PERF_EN defined, 3 stalled cycles give perf_rn_stall_cnt_o = 3.

Source files
------------

// File: rtl/rcu_rename_map_table_if.sv
// Rename/commit/freelist bundle of the RCU rename map table.
// The master drives the rename slots, the commit slots and the freelist read data.
// The slave is the map table itself.
interface rcu_rename_map_table_if #(
  parameter int ARCH_REG_WIDTH = 5,
  parameter int PHY_REG_WIDTH  = 6,
  parameter int FL_NUM_WIDTH   = 6
);
  // Flush request
  logic                      excep_rst_i;

  // Rename slots
  logic                      rn_first_valid_i;
  logic                      rn_second_valid_i;
  logic [ARCH_REG_WIDTH-1:0] rn_first_rs1_i;
  logic [ARCH_REG_WIDTH-1:0] rn_first_rs2_i;
  logic [ARCH_REG_WIDTH-1:0] rn_first_rd_i;
  logic [ARCH_REG_WIDTH-1:0] rn_second_rs1_i;
  logic [ARCH_REG_WIDTH-1:0] rn_second_rs2_i;
  logic [ARCH_REG_WIDTH-1:0] rn_second_rd_i;
  logic                      rn_first_rd_wen_i;
  logic                      rn_second_rd_wen_i;
  logic                      rn_ready_o;
  logic [PHY_REG_WIDTH-1:0]  rn_first_prs1_o;
  logic [PHY_REG_WIDTH-1:0]  rn_first_prs2_o;
  logic [PHY_REG_WIDTH-1:0]  rn_first_prd_o;
  logic [PHY_REG_WIDTH-1:0]  rn_first_lprd_o;
  logic [PHY_REG_WIDTH-1:0]  rn_second_prs1_o;
  logic [PHY_REG_WIDTH-1:0]  rn_second_prs2_o;
  logic [PHY_REG_WIDTH-1:0]  rn_second_prd_o;
  logic [PHY_REG_WIDTH-1:0]  rn_second_lprd_o;

  // Freelist pop side
  logic [FL_NUM_WIDTH-1:0]   fl_num_i;
  logic [PHY_REG_WIDTH-1:0]  fl_prd_first_i;
  logic [PHY_REG_WIDTH-1:0]  fl_prd_second_i;
  logic                      fl_rd_first_en_o;
  logic                      fl_rd_second_en_o;

  // Commit slots
  logic                      cm_first_valid_i;
  logic                      cm_second_valid_i;
  logic [ARCH_REG_WIDTH-1:0] cm_first_rd_i;
  logic [ARCH_REG_WIDTH-1:0] cm_second_rd_i;
  logic [PHY_REG_WIDTH-1:0]  cm_first_prd_i;
  logic [PHY_REG_WIDTH-1:0]  cm_second_prd_i;

  // Freelist commit/free side
  logic                      fl_rd_excep_first_en_o;
  logic                      fl_rd_excep_second_en_o;
  logic                      fl_wr_first_en_o;
  logic                      fl_wr_second_en_o;
  logic [PHY_REG_WIDTH-1:0]  fl_wdata_first_o;
  logic [PHY_REG_WIDTH-1:0]  fl_wdata_second_o;

  // Performance counters
  logic [31:0]               perf_rn_stall_cnt_o;
  logic [31:0]               perf_rn_insn_cnt_o;

  modport master (
    output excep_rst_i,
    output rn_first_valid_i, rn_second_valid_i,
    output rn_first_rs1_i, rn_first_rs2_i, rn_first_rd_i,
    output rn_second_rs1_i, rn_second_rs2_i, rn_second_rd_i,
    output rn_first_rd_wen_i, rn_second_rd_wen_i,
    input  rn_ready_o,
    input  rn_first_prs1_o, rn_first_prs2_o, rn_first_prd_o, rn_first_lprd_o,
    input  rn_second_prs1_o, rn_second_prs2_o, rn_second_prd_o, rn_second_lprd_o,
    output fl_num_i, fl_prd_first_i, fl_prd_second_i,
    input  fl_rd_first_en_o, fl_rd_second_en_o,
    output cm_first_valid_i, cm_second_valid_i,
    output cm_first_rd_i, cm_second_rd_i,
    output cm_first_prd_i, cm_second_prd_i,
    input  fl_rd_excep_first_en_o, fl_rd_excep_second_en_o,
    input  fl_wr_first_en_o, fl_wr_second_en_o,
    input  fl_wdata_first_o, fl_wdata_second_o,
    input  perf_rn_stall_cnt_o, perf_rn_insn_cnt_o
  );

  modport slave (
    input  excep_rst_i,
    input  rn_first_valid_i, rn_second_valid_i,
    input  rn_first_rs1_i, rn_first_rs2_i, rn_first_rd_i,
    input  rn_second_rs1_i, rn_second_rs2_i, rn_second_rd_i,
    input  rn_first_rd_wen_i, rn_second_rd_wen_i,
    output rn_ready_o,
    output rn_first_prs1_o, rn_first_prs2_o, rn_first_prd_o, rn_first_lprd_o,
    output rn_second_prs1_o, rn_second_prs2_o, rn_second_prd_o, rn_second_lprd_o,
    input  fl_num_i, fl_prd_first_i, fl_prd_second_i,
    output fl_rd_first_en_o, fl_rd_second_en_o,
    input  cm_first_valid_i, cm_second_valid_i,
    input  cm_first_rd_i, cm_second_rd_i,
    input  cm_first_prd_i, cm_second_prd_i,
    output fl_rd_excep_first_en_o, fl_rd_excep_second_en_o,
    output fl_wr_first_en_o, fl_wr_second_en_o,
    output fl_wdata_first_o, fl_wdata_second_o,
    output perf_rn_stall_cnt_o, perf_rn_insn_cnt_o
  );
endinterface

// File: rtl/rcu_rename_map_table.sv
// Two-wide register rename map table.
// Holds a speculative RAT, which rename updates, and an architectural RAT, which commit updates.
// Committed instructions return the physical register they displace to the freelist.
// An exception restores the speculative RAT from the post-commit architectural RAT.
// Optional feature macro: RCU_RENAME_PERF_EN enables the rename stall and instruction counters.
// When the macro is undefined, both counter outputs are tied to zero.
module rcu_rename_map_table #(
  parameter int ARCH_REG_NUM   = 32,
  parameter int ARCH_REG_WIDTH = 5,
  parameter int PHY_REG_WIDTH  = 6,
  parameter int FL_NUM_WIDTH   = 6
) (
  input logic                  clk,
  input logic                  rst,
  rcu_rename_map_table_if.slave bus
);

  typedef logic [PHY_REG_WIDTH-1:0] preg_t;

  preg_t spec_rat  [ARCH_REG_NUM];
  preg_t arch_rat  [ARCH_REG_NUM];
  preg_t arch_next [ARCH_REG_NUM];

  // ---------------------------------------------------------------------------
  // Rename: resource need, accept decision and freelist pops
  // ---------------------------------------------------------------------------
  logic       need_first;
  logic       need_second;
  logic [1:0] need_cnt;
  logic       ready;
  preg_t      prd_first;
  preg_t      prd_second;

  assign need_first  = bus.rn_first_valid_i  & bus.rn_first_rd_wen_i  & (bus.rn_first_rd_i  != '0);
  assign need_second = bus.rn_second_valid_i & bus.rn_second_rd_wen_i & (bus.rn_second_rd_i != '0);
  assign need_cnt    = {1'b0, need_first} + {1'b0, need_second};

  // The bundle is accepted all-or-nothing, and never while the table is being flushed.
  assign ready = ~bus.excep_rst_i & (bus.fl_num_i >= FL_NUM_WIDTH'(need_cnt));

  // Each slot reads its own freelist port, even when the first slot needs nothing.
  assign prd_first  = need_first  ? bus.fl_prd_first_i  : '0;
  assign prd_second = need_second ? bus.fl_prd_second_i : '0;

  assign bus.rn_ready_o        = ready;
  assign bus.fl_rd_first_en_o  = need_first  & ready;
  assign bus.fl_rd_second_en_o = need_second & ready;
  assign bus.rn_first_prd_o    = prd_first;
  assign bus.rn_second_prd_o   = prd_second;

  // Source and previous-dest lookup; the second slot sees the first slot's new mapping.
  assign bus.rn_first_prs1_o  = spec_rat[bus.rn_first_rs1_i];
  assign bus.rn_first_prs2_o  = spec_rat[bus.rn_first_rs2_i];
  assign bus.rn_first_lprd_o  = spec_rat[bus.rn_first_rd_i];
  assign bus.rn_second_prs1_o = (need_first && bus.rn_second_rs1_i == bus.rn_first_rd_i)
                                ? prd_first : spec_rat[bus.rn_second_rs1_i];
  assign bus.rn_second_prs2_o = (need_first && bus.rn_second_rs2_i == bus.rn_first_rd_i)
                                ? prd_first : spec_rat[bus.rn_second_rs2_i];
  assign bus.rn_second_lprd_o = (need_first && bus.rn_second_rd_i == bus.rn_first_rd_i)
                                ? prd_first : spec_rat[bus.rn_second_rd_i];

  // ---------------------------------------------------------------------------
  // Commit: architectural update and displaced-register selection
  // ---------------------------------------------------------------------------
  logic  commit_first;
  logic  commit_second;
  preg_t free_first;
  preg_t free_second;

  assign commit_first  = bus.cm_first_valid_i  & (bus.cm_first_rd_i  != '0);
  assign commit_second = bus.cm_second_valid_i & (bus.cm_second_rd_i != '0);

  assign bus.fl_rd_excep_first_en_o  = commit_first;
  assign bus.fl_rd_excep_second_en_o = commit_second;

  // A second commit to the same rd displaces the mapping the first commit just installed.
  assign free_first  = arch_rat[bus.cm_first_rd_i];
  assign free_second = (commit_first && bus.cm_first_rd_i == bus.cm_second_rd_i)
                       ? bus.cm_first_prd_i : arch_rat[bus.cm_second_rd_i];

  // Post-commit architectural RAT, applied in slot order so the second slot wins.
  always_comb begin
    // NOTE: assign the whole array a default first; otherwise every unwritten entry becomes a latch.
    arch_next = arch_rat;
    if (commit_first)  arch_next[bus.cm_first_rd_i]  = bus.cm_first_prd_i;
    if (commit_second) arch_next[bus.cm_second_rd_i] = bus.cm_second_prd_i;
  end

  // Architectural RAT register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: both RATs must reset to the identity map; this is real state, not a scratch memory.
      for (int i = 0; i < ARCH_REG_NUM; i++) arch_rat[i] <= preg_t'(i);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every reader sees pre-edge values.
      arch_rat <= arch_next;
    end
  end

  // Speculative RAT: restore on flush, otherwise take the accepted bundle with the second slot winning.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REG_NUM; i++) spec_rat[i] <= preg_t'(i);
    end else if (bus.excep_rst_i) begin
      spec_rat <= arch_next;
    end else if (ready) begin
      if (need_first)  spec_rat[bus.rn_first_rd_i]  <= prd_first;
      if (need_second) spec_rat[bus.rn_second_rd_i] <= prd_second;
    end
  end

  // Return displaced registers to the freelist one cycle after commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.fl_wr_first_en_o  <= 1'b0;
      bus.fl_wr_second_en_o <= 1'b0;
      bus.fl_wdata_first_o  <= '0;
      bus.fl_wdata_second_o <= '0;
    end else begin
      bus.fl_wr_first_en_o  <= commit_first;
      bus.fl_wr_second_en_o <= commit_second;
      bus.fl_wdata_first_o  <= commit_first  ? free_first  : '0;
      bus.fl_wdata_second_o <= commit_second ? free_second : '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef RCU_RENAME_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] insn_cnt;

  // Count stalled rename cycles and accepted valid slots; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      insn_cnt  <= '0;
    end else begin
      if ((bus.rn_first_valid_i | bus.rn_second_valid_i) & ~ready) stall_cnt <= stall_cnt + 32'd1;
      if (ready) insn_cnt <= insn_cnt + {31'b0, bus.rn_first_valid_i} + {31'b0, bus.rn_second_valid_i};
    end
  end

  assign bus.perf_rn_stall_cnt_o = stall_cnt;
  assign bus.perf_rn_insn_cnt_o  = insn_cnt;
`else
  assign bus.perf_rn_stall_cnt_o = '0;
  assign bus.perf_rn_insn_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_rcu_rename_map_table.sv
// Bench for rcu_rename_map_table: directed scenarios followed by random traffic,
// all checked against a sequential-semantics model of the two RATs.
module tb_rcu_rename_map_table;

  logic clk;
  logic rst;

  rcu_rename_map_table_if bus ();

  rcu_rename_map_table dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: the RAT contents as plain integer maps.
  int          spec_m [32];
  int          arch_m [32];
  bit          pend1, pend2;
  int          pfree1, pfree2;
  logic [31:0] stall_m, insn_m;

  // Next state computed before each clock edge.
  int          nspec [32];
  int          narch [32];
  bit          npend1, npend2;
  int          nfree1, nfree2;
  logic [31:0] nstall, ninsn;
  bit          rst_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      spec_m[i] = i;
      arch_m[i] = i;
    end
    pend1 = 0; pend2 = 0; pfree1 = 0; pfree2 = 0;
    stall_m = '0; insn_m = '0;
  endtask

  task automatic idle();
    bus.excep_rst_i        = 1'b0;
    bus.rn_first_valid_i   = 1'b0;
    bus.rn_second_valid_i  = 1'b0;
    bus.rn_first_rs1_i     = '0;
    bus.rn_first_rs2_i     = '0;
    bus.rn_first_rd_i      = '0;
    bus.rn_second_rs1_i    = '0;
    bus.rn_second_rs2_i    = '0;
    bus.rn_second_rd_i     = '0;
    bus.rn_first_rd_wen_i  = 1'b0;
    bus.rn_second_rd_wen_i = 1'b0;
    bus.fl_num_i           = 6'd31;
    bus.fl_prd_first_i     = '0;
    bus.fl_prd_second_i    = '0;
    bus.cm_first_valid_i   = 1'b0;
    bus.cm_second_valid_i  = 1'b0;
    bus.cm_first_rd_i      = '0;
    bus.cm_second_rd_i     = '0;
    bus.cm_first_prd_i     = '0;
    bus.cm_second_prd_i    = '0;
  endtask

  // Check combinational outputs against a model that renames the two slots one after the other.
  task automatic settle_check();
    int  view [32];
    int  commit_view [32];
    bit  n1, n2, c1, c2, rdy;
    int  cnt, p1, p2, v;
    #1;
    rst_seen = rst;
    n1  = bus.rn_first_valid_i  && bus.rn_first_rd_wen_i  && bus.rn_first_rd_i  != 0;
    n2  = bus.rn_second_valid_i && bus.rn_second_rd_wen_i && bus.rn_second_rd_i != 0;
    cnt = int'(n1) + int'(n2);
    rdy = !bus.excep_rst_i && (int'(bus.fl_num_i) >= cnt);
    p1  = n1 ? int'(bus.fl_prd_first_i)  : 0;
    p2  = n2 ? int'(bus.fl_prd_second_i) : 0;

    check("ready",    32'(bus.rn_ready_o),        32'(rdy));
    check("pop_a",    32'(bus.fl_rd_first_en_o),  32'(n1 && rdy));
    check("pop_b",    32'(bus.fl_rd_second_en_o), 32'(n2 && rdy));
    check("prd_a",    32'(bus.rn_first_prd_o),    32'(p1));
    check("prd_b",    32'(bus.rn_second_prd_o),   32'(p2));

    view = spec_m;
    check("prs1_a",   32'(bus.rn_first_prs1_o),  32'(view[bus.rn_first_rs1_i]));
    check("prs2_a",   32'(bus.rn_first_prs2_o),  32'(view[bus.rn_first_rs2_i]));
    check("lprd_a",   32'(bus.rn_first_lprd_o),  32'(view[bus.rn_first_rd_i]));
    if (n1) view[bus.rn_first_rd_i] = p1;
    check("prs1_b",   32'(bus.rn_second_prs1_o), 32'(view[bus.rn_second_rs1_i]));
    check("prs2_b",   32'(bus.rn_second_prs2_o), 32'(view[bus.rn_second_rs2_i]));
    check("lprd_b",   32'(bus.rn_second_lprd_o), 32'(view[bus.rn_second_rd_i]));
    if (n2) view[bus.rn_second_rd_i] = p2;

    // Commits retire in order: each one frees whatever its rd mapped to just before it.
    commit_view = arch_m;
    c1 = bus.cm_first_valid_i  && bus.cm_first_rd_i  != 0;
    c2 = bus.cm_second_valid_i && bus.cm_second_rd_i != 0;
    nfree1 = 0; nfree2 = 0;
    if (c1) begin
      nfree1 = commit_view[bus.cm_first_rd_i];
      commit_view[bus.cm_first_rd_i] = int'(bus.cm_first_prd_i);
    end
    if (c2) begin
      nfree2 = commit_view[bus.cm_second_rd_i];
      commit_view[bus.cm_second_rd_i] = int'(bus.cm_second_prd_i);
    end
    check("xen_a", 32'(bus.fl_rd_excep_first_en_o),  32'(c1));
    check("xen_b", 32'(bus.fl_rd_excep_second_en_o), 32'(c2));

    narch  = commit_view;
    if (bus.excep_rst_i) nspec = commit_view;
    else if (rdy)        nspec = view;
    else                 nspec = spec_m;
    npend1 = c1;
    npend2 = c2;

    v = int'(bus.rn_first_valid_i) + int'(bus.rn_second_valid_i);
`ifdef RCU_RENAME_PERF_EN
    nstall = stall_m + ((v != 0 && !rdy) ? 32'd1 : 32'd0);
    ninsn  = insn_m + (rdy ? 32'(v) : 32'd0);
`else
    nstall = '0;
    ninsn  = '0;
    if (v < 0) nstall = '1;
`endif
  endtask

  // Advance one clock, update the model and check the registered outputs.
  task automatic clock_check();
    @(posedge clk);
    #1;
    if (rst_seen) begin
      model_reset();
    end else begin
      spec_m = nspec;
      arch_m = narch;
      pend1  = npend1;
      pend2  = npend2;
      pfree1 = nfree1;
      pfree2 = nfree2;
      stall_m = nstall;
      insn_m  = ninsn;
    end
    check("wr_en_a", 32'(bus.fl_wr_first_en_o),  32'(pend1));
    check("wr_en_b", 32'(bus.fl_wr_second_en_o), 32'(pend2));
    if (pend1) check("wdata_a", 32'(bus.fl_wdata_first_o),  32'(pfree1));
    if (pend2) check("wdata_b", 32'(bus.fl_wdata_second_o), 32'(pfree2));
    if (rst_seen) begin
      check("rst_wdata_a", 32'(bus.fl_wdata_first_o),  32'd0);
      check("rst_wdata_b", 32'(bus.fl_wdata_second_o), 32'd0);
    end
    check("perf_stall", bus.perf_rn_stall_cnt_o, stall_m);
    check("perf_insn",  bus.perf_rn_insn_cnt_o,  insn_m);
    @(negedge clk);
  endtask

  task automatic step();
    settle_check();
    clock_check();
  endtask

  function automatic logic [4:0] pick_reg();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  task automatic drive_random();
    bus.excep_rst_i        = ($urandom_range(0, 15) == 0);
    bus.rn_first_valid_i   = ($urandom_range(0, 3) != 0);
    bus.rn_second_valid_i  = ($urandom_range(0, 3) != 0);
    bus.rn_first_rd_wen_i  = ($urandom_range(0, 4) != 0);
    bus.rn_second_rd_wen_i = ($urandom_range(0, 4) != 0);
    bus.rn_first_rs1_i     = pick_reg();
    bus.rn_first_rs2_i     = pick_reg();
    bus.rn_first_rd_i      = pick_reg();
    bus.rn_second_rs1_i    = pick_reg();
    bus.rn_second_rs2_i    = pick_reg();
    bus.rn_second_rd_i     = pick_reg();
    bus.fl_num_i           = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(3, 63)) : 6'($urandom_range(0, 2));
    bus.fl_prd_first_i     = 6'($urandom_range(0, 63));
    bus.fl_prd_second_i    = 6'($urandom_range(0, 63));
    bus.cm_first_valid_i   = ($urandom_range(0, 2) == 0);
    bus.cm_second_valid_i  = ($urandom_range(0, 2) == 0);
    bus.cm_first_rd_i      = pick_reg();
    bus.cm_second_rd_i     = pick_reg();
    bus.cm_first_prd_i     = 6'($urandom_range(0, 63));
    bus.cm_second_prd_i    = 6'($urandom_range(0, 63));
    rst                    = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset cycle with a commit pending: it must be dropped and counters stay cleared.
    bus.cm_first_valid_i = 1'b1;
    bus.cm_first_rd_i    = 5'd3;
    bus.cm_first_prd_i   = 6'd50;
    step();
    check("reset_wr_en", 32'(bus.fl_wr_first_en_o), 32'd0);
    rst = 1'b0;
    idle();

    // Three stalled cycles: a slot needs a register but the freelist is empty.
    for (int i = 0; i < 3; i++) begin
      bus.rn_first_valid_i  = 1'b1;
      bus.rn_first_rd_wen_i = 1'b1;
      bus.rn_first_rd_i     = 5'd3;
      bus.fl_num_i          = 6'd0;
      step();
    end
`ifdef RCU_RENAME_PERF_EN
    check("stall_three", bus.perf_rn_stall_cnt_o, 32'd3);
`endif
    idle();

    // Rename x1 -> p32, then read it back.
    bus.rn_first_valid_i  = 1'b1;
    bus.rn_first_rd_wen_i = 1'b1;
    bus.rn_first_rd_i     = 5'd1;
    bus.fl_prd_first_i    = 6'd32;
    bus.fl_num_i          = 6'd31;
    settle_check();
    check("x1_ready", 32'(bus.rn_ready_o),      32'd1);
    check("x1_prd",   32'(bus.rn_first_prd_o),  32'd32);
    check("x1_lprd",  32'(bus.rn_first_lprd_o), 32'd1);
    clock_check();
    idle();
    bus.rn_first_rs1_i = 5'd1;
    settle_check();
    check("x1_prs1", 32'(bus.rn_first_prs1_o), 32'd32);
    clock_check();

    // Same-bundle bypass: both slots write x5, second reads x5.
    idle();
    bus.rn_first_valid_i   = 1'b1;
    bus.rn_first_rd_wen_i  = 1'b1;
    bus.rn_first_rd_i      = 5'd5;
    bus.fl_prd_first_i     = 6'd33;
    bus.rn_second_valid_i  = 1'b1;
    bus.rn_second_rd_wen_i = 1'b1;
    bus.rn_second_rs1_i    = 5'd5;
    bus.rn_second_rd_i     = 5'd5;
    bus.fl_prd_second_i    = 6'd34;
    settle_check();
    check("byp_prs1", 32'(bus.rn_second_prs1_o), 32'd33);
    check("byp_lprd", 32'(bus.rn_second_lprd_o), 32'd33);
    clock_check();
    idle();
    bus.rn_first_rs2_i = 5'd5;
    settle_check();
    check("x5_final", 32'(bus.rn_first_prs2_o), 32'd34);
    clock_check();

    // Freelist occupancy boundary: one entry is not enough for two, two is.
    idle();
    bus.rn_first_valid_i   = 1'b1;
    bus.rn_first_rd_wen_i  = 1'b1;
    bus.rn_first_rd_i      = 5'd10;
    bus.rn_second_valid_i  = 1'b1;
    bus.rn_second_rd_wen_i = 1'b1;
    bus.rn_second_rd_i     = 5'd11;
    bus.fl_prd_first_i     = 6'd41;
    bus.fl_prd_second_i    = 6'd42;
    bus.fl_num_i           = 6'd1;
    settle_check();
    check("fl1_ready", 32'(bus.rn_ready_o), 32'd0);
    check("fl1_pops",  32'({bus.fl_rd_first_en_o, bus.fl_rd_second_en_o}), 32'd0);
    clock_check();
    bus.fl_num_i = 6'd2;
    settle_check();
    check("fl2_pops",  32'({bus.fl_rd_first_en_o, bus.fl_rd_second_en_o}), 32'd3);
    clock_check();

    // Double commit to x5: frees the old arch mapping, then the first slot's mapping.
    idle();
    bus.cm_first_valid_i  = 1'b1;
    bus.cm_first_rd_i     = 5'd5;
    bus.cm_first_prd_i    = 6'd33;
    bus.cm_second_valid_i = 1'b1;
    bus.cm_second_rd_i    = 5'd5;
    bus.cm_second_prd_i   = 6'd34;
    settle_check();
    check("cm_xen", 32'({bus.fl_rd_excep_first_en_o, bus.fl_rd_excep_second_en_o}), 32'd3);
    clock_check();
    check("cm_free_a", 32'(bus.fl_wdata_first_o),  32'd5);
    check("cm_free_b", 32'(bus.fl_wdata_second_o), 32'd33);

    // Speculative x7 -> p40, then flush restores x7 -> p7.
    idle();
    bus.rn_first_valid_i  = 1'b1;
    bus.rn_first_rd_wen_i = 1'b1;
    bus.rn_first_rd_i     = 5'd7;
    bus.fl_prd_first_i    = 6'd40;
    step();
    bus.excep_rst_i = 1'b1;
    settle_check();
    check("flush_ready", 32'(bus.rn_ready_o), 32'd0);
    clock_check();
    idle();
    bus.rn_first_rs1_i = 5'd7;
    settle_check();
    check("flush_x7", 32'(bus.rn_first_prs1_o), 32'd7);
    clock_check();

    // x0 destination and rd_wen = 0 need nothing.
    idle();
    bus.rn_first_valid_i   = 1'b1;
    bus.rn_first_rd_wen_i  = 1'b1;
    bus.rn_first_rd_i      = 5'd0;
    bus.rn_second_valid_i  = 1'b1;
    bus.rn_second_rd_wen_i = 1'b0;
    bus.rn_second_rd_i     = 5'd9;
    bus.fl_prd_first_i     = 6'd45;
    bus.fl_prd_second_i    = 6'd46;
    bus.fl_num_i           = 6'd0;
    settle_check();
    check("x0_pops", 32'({bus.fl_rd_first_en_o, bus.fl_rd_second_en_o}), 32'd0);
    check("x0_prd",  32'({bus.rn_first_prd_o, bus.rn_second_prd_o}), 32'd0);
    clock_check();
    idle();
    bus.rn_first_rs1_i = 5'd0;
    bus.rn_first_rs2_i = 5'd9;
    settle_check();
    check("x0_map", 32'(bus.rn_first_prs1_o), 32'd0);
    check("x9_map", 32'(bus.rn_first_prs2_o), 32'd9);
    clock_check();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive_random();
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
